// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and defaults for the SRAM256x32 bus controller.
// State encoding is kept here so that sibling blocks and benches agree on it.
package sram_bus_ctrl_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_bus_ctrl_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level, cleared by synchronous reset.
// The output is the last flop of a SYNC-deep chain.
module sram_bus_ctrl_sync_bit #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC-1];

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-outstanding master for the SRAM256x32 start/done handshake.
// Owns the shared databus during writes and returns read data or timeout status to the core.
//
// state | meaning
// IDLE  | accepts a core request unless done from the previous access is still high
// START | one-cycle mem_start pulse; bus driven on writes
// WAIT  | waits for done_rise or timeout; bus driven on writes
// RESP  | one-cycle response to the core
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64,
  parameter int SYNC    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_start,
  input  logic          mem_done,
  inout  wire  [DW-1:0] mem_data
);

  localparam int TW = $clog2(TIMEOUT);
  // Leaving WAIT as the timer steps onto TIMEOUT-1 puts the error response TIMEOUT cycles after START.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [DW-1:0] wbuf_q, wbuf_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          done_prev_q;
  logic          done_s;
  logic          done_rise;
  logic          bus_en;

  sram_bus_ctrl_sync_bit #(.SYNC(SYNC)) u_done_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_done),
    .q     (done_s)
  );

  assign done_rise = done_s & ~done_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wbuf_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wbuf_q      <= wbuf_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      done_prev_q <= done_s;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    write_d = write_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !done_s) begin
          addr_d  = addr;
          write_d = we;
          wbuf_d  = wdata;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // done wins over a timeout landing on the same cycle
        if (done_rise) begin
          err_d = 1'b0;
          if (!write_q) begin
            rdata_d = mem_data;
          end
          state_d = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    mem_start  = 1'b0;
    resp_valid = 1'b0;
    bus_en     = 1'b0;
    case (state_q)
      ST_IDLE:  ready = ~done_s;
      ST_START: begin
        mem_start = 1'b1;
        bus_en    = write_q;
      end
      ST_WAIT:  bus_en = write_q;
      ST_RESP:  resp_valid = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  assign resp_err  = resp_valid & err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_write = write_q;
  assign mem_data  = bus_en ? wbuf_q : {DW{1'bz}};

endmodule
